// File: rtl/l1_l2_port_arbiter.sv
// l1_l2_port_arbiter
//
// Shares the single downstream L2 request port between the L1 instruction-cache
// miss path (I) and the L1 data-cache path (D: misses, write-through, CLF).
// One miss is outstanding at a time. A granted request is latched onto the l2_*
// outputs, strobed to L2 with l2_enable for one cycle, and the returned line goes
// back to the requester with a one-cycle ack. Round-robin arbitration with a
// one-cycle post-completion mask stops either side from starving the other. A
// watchdog abandons an L2 access that never completes and raises a sticky error.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   i_req/i_addr        L1_I miss request (level, held until i_ack) and address
//   i_ack/i_data        L1_I completion pulse and returned line (held afterwards)
//   d_req/d_addr/d_we/d_wdata/d_wsize/d_clf
//                       L1_D request (level, held until d_ack) and its fields
//   d_ack/d_data        L1_D completion pulse and returned line (held afterwards)
//   l2_enable           one-cycle request strobe to L2
//   l2_addr/l2_we/l2_wdata/l2_wsize/l2_clf
//                       request fields latched at grant, held until next grant
//   l2_done/l2_data     L2 completion and line, sampled only while waiting
//   busy                high whenever a transaction is in flight
//   timeout_err         sticky watchdog flag, cleared only by reset

module l1_l2_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          i_req,
  input  logic [63:0]   i_addr,
  output logic          i_ack,
  output logic [127:0]  i_data,

  input  logic          d_req,
  input  logic [63:0]   d_addr,
  input  logic          d_we,
  input  logic [63:0]   d_wdata,
  input  logic [2:0]    d_wsize,
  input  logic          d_clf,
  output logic          d_ack,
  output logic [127:0]  d_data,

  output logic          l2_enable,
  output logic [63:0]   l2_addr,
  output logic          l2_we,
  output logic [63:0]   l2_wdata,
  output logic [2:0]    l2_wsize,
  output logic          l2_clf,
  input  logic          l2_done,
  input  logic [127:0]  l2_data,

  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StRespond = 2'd3
  } state_e;

  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } owner_e;

  // Last WAIT cycle in which the counter may still see l2_done.
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  owner_e             last_grant_q, last_grant_d;
  // mask[0] blocks I, mask[1] blocks D for the single IDLE cycle after completion.
  logic [1:0]         mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [63:0]        l2_addr_q, l2_addr_d;
  logic               l2_we_q, l2_we_d;
  logic [63:0]        l2_wdata_q, l2_wdata_d;
  logic [2:0]         l2_wsize_q, l2_wsize_d;
  logic               l2_clf_q, l2_clf_d;

  logic [127:0]       i_data_q, i_data_d;
  logic [127:0]       d_data_q, d_data_d;
  logic               timeout_err_q, timeout_err_d;

  logic               elig_i, elig_d;
  logic               grant_d;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    l2_addr_d     = l2_addr_q;
    l2_we_d       = l2_we_q;
    l2_wdata_d    = l2_wdata_q;
    l2_wsize_d    = l2_wsize_q;
    l2_clf_d      = l2_clf_q;
    i_data_d      = i_data_q;
    d_data_d      = d_data_q;
    timeout_err_d = timeout_err_q;

    elig_i  = i_req & ~mask_q[0];
    elig_d  = d_req & ~mask_q[1];
    // D wins when it is the only eligible requester, or when both are eligible
    // and I was served last.
    grant_d = elig_d & (~elig_i | (last_grant_q == OwnI));

    unique case (state_q)
      StIdle: begin
        mask_d = 2'b00;
        if (elig_i || elig_d) begin
          owner_d = owner_e'(grant_d);
          if (grant_d) begin
            l2_addr_d  = d_addr;
            l2_we_d    = d_we;
            l2_wdata_d = d_wdata;
            l2_wsize_d = d_wsize;
            l2_clf_d   = d_clf;
          end else begin
            // Instruction fetches are always plain reads.
            l2_addr_d  = i_addr;
            l2_we_d    = 1'b0;
            l2_wdata_d = '0;
            l2_wsize_d = '0;
            l2_clf_d   = 1'b0;
          end
          cnt_d   = '0;
          state_d = StIssue;
        end
      end

      StIssue: begin
        state_d = StWait;
      end

      StWait: begin
        // A completion on the final watchdog cycle takes priority over the timeout.
        if (l2_done) begin
          if (owner_q == OwnD) begin
            d_data_d = l2_data;
          end else begin
            i_data_d = l2_data;
          end
          state_d = StRespond;
        end else if (cnt_q == TimeoutLast) begin
          timeout_err_d = 1'b1;
          if (owner_q == OwnD) begin
            d_data_d = '0;
          end else begin
            i_data_d = '0;
          end
          state_d = StRespond;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StRespond: begin
        last_grant_d = owner_q;
        // The requester still holds req during this cycle; mask it for one IDLE
        // cycle so the other side gets a chance.
        mask_d       = (owner_q == OwnD) ? 2'b10 : 2'b01;
        state_d      = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      owner_q       <= OwnI;
      last_grant_q  <= OwnI;
      mask_q        <= 2'b00;
      cnt_q         <= '0;
      l2_addr_q     <= '0;
      l2_we_q       <= 1'b0;
      l2_wdata_q    <= '0;
      l2_wsize_q    <= '0;
      l2_clf_q      <= 1'b0;
      i_data_q      <= '0;
      d_data_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      l2_addr_q     <= l2_addr_d;
      l2_we_q       <= l2_we_d;
      l2_wdata_q    <= l2_wdata_d;
      l2_wsize_q    <= l2_wsize_d;
      l2_clf_q      <= l2_clf_d;
      i_data_q      <= i_data_d;
      d_data_q      <= d_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign l2_enable   = (state_q == StIssue);
  assign busy        = (state_q != StIdle);
  assign i_ack       = (state_q == StRespond) && (owner_q == OwnI);
  assign d_ack       = (state_q == StRespond) && (owner_q == OwnD);
  assign i_data      = i_data_q;
  assign d_data      = d_data_q;
  assign l2_addr     = l2_addr_q;
  assign l2_we       = l2_we_q;
  assign l2_wdata    = l2_wdata_q;
  assign l2_wsize    = l2_wsize_q;
  assign l2_clf      = l2_clf_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_l1_l2_port_arbiter.sv
// Self-checking bench for l1_l2_port_arbiter. Two requester drivers and an L2
// responder produce stimulus; the responder pushes the expected completion
// (cycle, line, timeout) into a queue, and a monitor derives grants from the
// arbitration rules and pops completions whenever the DUT acks.

module tb_l1_l2_port_arbiter;

  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [63:0]   i_addr;
  logic          i_ack;
  logic [127:0]  i_data;
  logic          d_req;
  logic [63:0]   d_addr;
  logic          d_we;
  logic [63:0]   d_wdata;
  logic [2:0]    d_wsize;
  logic          d_clf;
  logic          d_ack;
  logic [127:0]  d_data;
  logic          l2_enable;
  logic [63:0]   l2_addr;
  logic          l2_we;
  logic [63:0]   l2_wdata;
  logic [2:0]    l2_wsize;
  logic          l2_clf;
  logic          l2_done;
  logic [127:0]  l2_data;
  logic          busy;
  logic          timeout_err;

  l1_l2_port_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ack      (i_ack),
    .i_data     (i_data),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_we       (d_we),
    .d_wdata    (d_wdata),
    .d_wsize    (d_wsize),
    .d_clf      (d_clf),
    .d_ack      (d_ack),
    .d_data     (d_data),
    .l2_enable  (l2_enable),
    .l2_addr    (l2_addr),
    .l2_we      (l2_we),
    .l2_wdata   (l2_wdata),
    .l2_wsize   (l2_wsize),
    .l2_clf     (l2_clf),
    .l2_done    (l2_done),
    .l2_data    (l2_data),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    bit           to;
    int           ack_cyc;
  } rsp_t;

  typedef struct {
    int           d;       // WAIT cycle in which done is driven; >= TO means never
    bit           glitch;  // pulse done during the ISSUE cycle
    logic [127:0] data;
  } dir_t;

  rsp_t rsp_q[$];
  dir_t dir_q[$];
  bit   grant_log[$];
  bit   rsp_en = 1'b0;
  bit   mon_en = 1'b0;

  // Reference model state (transaction level)
  bit           mb;          // a transaction is in flight
  bit           idle_prev;   // previous cycle could grant
  bit           cur_own;     // 0 = I, 1 = D
  int           grant_cyc;
  logic [63:0]  g_addr;
  logic         g_we;
  logic [63:0]  g_wdata;
  logic [2:0]   g_wsize;
  logic         g_clf;
  bit           last_own;
  int           last_ack_cyc;
  bit           exp_terr;
  logic [127:0] last_i_data;
  logic [127:0] last_d_data;

  task automatic model_reset();
    mb           = 1'b0;
    idle_prev    = 1'b0;
    last_own     = 1'b0;
    last_ack_cyc = -100;
    exp_terr     = 1'b0;
    last_i_data  = '0;
    last_d_data  = '0;
    rsp_q.delete();
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0b required=%0b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_dir(input int d, input bit g, input logic [127:0] v);
    dir_t e;
    e.d      = d;
    e.glitch = g;
    e.data   = v;
    dir_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin : mon
    bit   masked, el_i, el_d, exp_en, own, ack_now;
    rsp_t r;
    #1;
    if (mon_en && !reset) begin
      masked = (last_ack_cyc == cyc - 2);
      el_i   = i_req && !(masked && !last_own);
      el_d   = d_req && !(masked && last_own);
      exp_en = idle_prev && (el_i || el_d);
      chk1("l2_enable", l2_enable, exp_en);
      if (exp_en) begin
        own       = el_d && (!el_i || !last_own);
        mb        = 1'b1;
        cur_own   = own;
        grant_cyc = cyc;
        grant_log.push_back(own);
        g_addr  = own ? d_addr  : i_addr;
        g_we    = own ? d_we    : 1'b0;
        g_wdata = own ? d_wdata : 64'd0;
        g_wsize = own ? d_wsize : 3'd0;
        g_clf   = own ? d_clf   : 1'b0;
        chkw("l2_addr", 128'(l2_addr), 128'(g_addr));
        chk1("l2_we", l2_we, g_we);
        chkw("l2_wdata", 128'(l2_wdata), 128'(g_wdata));
        chkw("l2_wsize", 128'(l2_wsize), 128'(g_wsize));
        chk1("l2_clf", l2_clf, g_clf);
      end
      chk1("busy", busy, mb);
      ack_now = mb && (rsp_q.size() > 0) && (rsp_q[0].ack_cyc == cyc);
      chk1("i_ack", i_ack, ack_now && !cur_own);
      chk1("d_ack", d_ack, ack_now && cur_own);
      if (ack_now) begin
        r = rsp_q.pop_front();
        if (cur_own) last_d_data = r.data;
        else         last_i_data = r.data;
        exp_terr = exp_terr | r.to;
        chkw("i_data", i_data, last_i_data);
        chkw("d_data", d_data, last_d_data);
        chk1("timeout_err", timeout_err, exp_terr);
        chkw("l2_addr_hold", 128'(l2_addr), 128'(g_addr));
        chkw("l2_wdata_hold", 128'(l2_wdata), 128'(g_wdata));
        last_own     = cur_own;
        last_ack_cyc = cyc;
        mb           = 1'b0;
      end else if (mb && (cyc > grant_cyc + TO + 6)) begin
        checks++;
        fails++;
        $display("FAIL ack_timeout actual=no_ack required=ack (grant cycle %0d)", grant_cyc);
        mb = 1'b0;
        rsp_q.delete();
      end
      idle_prev = !mb && !ack_now;
    end
  end

  // L2 responder
  initial begin : l2_model
    dir_t         dd;
    rsp_t         r;
    int           c, w;
    l2_done = 1'b0;
    l2_data = '0;
    forever begin
      @(negedge clk);
      if (rsp_en && !reset && l2_enable) begin
        if (dir_q.size() > 0) begin
          dd = dir_q.pop_front();
        end else begin
          dd.d      = int'($urandom_range(0, TO + 3));
          dd.glitch = 1'($urandom_range(0, 1));
          dd.data   = rand128();
        end
        c         = cyc;
        w         = (dd.d > TO - 1) ? TO - 1 : dd.d;
        r.data    = (dd.d <= TO - 1) ? dd.data : 128'd0;
        r.to      = (dd.d > TO - 1);
        r.ack_cyc = c + 2 + w;
        rsp_q.push_back(r);
        if (dd.glitch) begin
          l2_done = 1'b1;
          l2_data = rand128();
        end
        @(negedge clk);
        l2_done = 1'b0;
        if (dd.d <= TO - 1) begin
          repeat (dd.d) @(negedge clk);
          l2_done = 1'b1;
          l2_data = dd.data;
          @(negedge clk);
          l2_done = 1'b0;
        end
      end
    end
  end

  task automatic do_i(input logic [63:0] addr, input int gap, input bit scr);
    bit ok;
    repeat (gap) @(negedge clk);
    i_req  = 1'b1;
    i_addr = addr;
    ok     = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (i_ack) begin
        ok = 1'b1;
        break;
      end
      if (scr && ($urandom_range(0, 1) == 1)) i_addr = {$urandom(), $urandom()};
    end
    i_req = 1'b0;
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL i_req_wait actual=no_ack required=ack");
    end
  endtask

  task automatic do_d(input logic [63:0] addr, input logic we, input logic [63:0] wdata,
                      input logic [2:0] wsize, input logic clf, input int gap, input bit scr);
    bit ok;
    repeat (gap) @(negedge clk);
    d_req   = 1'b1;
    d_addr  = addr;
    d_we    = we;
    d_wdata = wdata;
    d_wsize = wsize;
    d_clf   = clf;
    ok      = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (d_ack) begin
        ok = 1'b1;
        break;
      end
      if (scr && ($urandom_range(0, 1) == 1)) begin
        d_addr  = {$urandom(), $urandom()};
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = {$urandom(), $urandom()};
        d_wsize = 3'($urandom_range(0, 7));
        d_clf   = 1'($urandom_range(0, 1));
      end
    end
    d_req = 1'b0;
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL d_req_wait actual=no_ack required=ack");
    end
  endtask

  task automatic rand_d(input int gap, input bit scr);
    do_d({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), {$urandom(), $urandom()},
         3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), gap, scr);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int  idx;
    bit  seen;
    bit  g0, g1, g2;
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_addr  = '0;
    d_we    = 1'b0;
    d_wdata = '0;
    d_wsize = '0;
    d_clf   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_l2_enable", l2_enable, 1'b0);
    chk1("rst_i_ack", i_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    chkw("rst_l2_addr", 128'(l2_addr), 128'd0);
    chkw("rst_i_data", i_data, 128'd0);
    chkw("rst_d_data", d_data, 128'd0);

    reset  = 1'b0;
    mon_en = 1'b1;
    rsp_en = 1'b1;

    // Single I miss: done three cycles after l2_enable
    push_dir(2, 1'b0, {16{8'hA5}});
    do_i(64'd19999, 1, 1'b0);
    chkw("dir_i_data", i_data, {16{8'hA5}});
    chkw("dir_i_l2_addr", 128'(l2_addr), 128'd19999);
    chk1("dir_i_l2_we", l2_we, 1'b0);

    // D write-through, with a done glitch during ISSUE
    push_dir(0, 1'b1, rand128());
    do_d(64'h0000_0000_0000_1000, 1'b1, 64'h1122334455667788, 3'd3, 1'b0, 1, 1'b0);
    chk1("dir_d_l2_we", l2_we, 1'b1);
    chkw("dir_d_l2_wdata", 128'(l2_wdata), 128'h1122334455667788);
    chkw("dir_d_l2_wsize", 128'(l2_wsize), 128'd3);

    // Done on the exact watchdog cycle: data returned, no error
    push_dir(TO - 1, 1'b1, rand128());
    do_i({$urandom(), $urandom()}, 1, 1'b0);
    chk1("boundary_timeout_err", timeout_err, 1'b0);

    // Both requesting and held: D, I, D
    idx = grant_log.size();
    push_dir(1, 1'b0, rand128());
    push_dir(1, 1'b0, rand128());
    push_dir(1, 1'b0, rand128());
    fork
      begin
        rand_d(1, 1'b0);
        rand_d(0, 1'b0);
      end
      do_i({$urandom(), $urandom()}, 1, 1'b0);
    join
    if (grant_log.size() >= idx + 3) begin
      g0 = grant_log[idx];
      g1 = grant_log[idx + 1];
      g2 = grant_log[idx + 2];
      chk1("rr_first_is_d", g0, 1'b1);
      chk1("rr_second_is_i", g1, 1'b0);
      chk1("rr_third_is_d", g2, 1'b1);
    end else begin
      checks++;
      fails++;
      $display("FAIL rr_grants actual=%0d required=3", grant_log.size() - idx);
    end

    // Watchdog: L2 never answers, then a successful access keeps the flag
    push_dir(TO + 5, 1'b0, rand128());
    rand_d(1, 1'b0);
    chk1("wd_timeout_err", timeout_err, 1'b1);
    chkw("wd_d_data_zero", d_data, 128'd0);
    push_dir(1, 1'b0, rand128());
    do_i({$urandom(), $urandom()}, 1, 1'b0);
    chk1("wd_sticky", timeout_err, 1'b1);

    // Randomised traffic from both sides
    fork
      repeat (25) do_i({$urandom(), $urandom()}, int'($urandom_range(0, 3)), 1'b1);
      repeat (25) rand_d(int'($urandom_range(0, 3)), 1'b1);
    join
    repeat (4) @(negedge clk);

    // Reset while waiting on L2
    mon_en = 1'b0;
    rsp_en = 1'b0;
    i_req  = 1'b1;
    i_addr = 64'h0000_0000_0000_DEAD;
    seen   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (l2_enable) begin
        seen = 1'b1;
        break;
      end
    end
    chk1("rst_test_enable_seen", seen, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_l2_enable", l2_enable, 1'b0);
    chk1("mid_rst_ack", i_ack | d_ack, 1'b0);
    chkw("mid_rst_l2_addr", 128'(l2_addr), 128'd0);
    chkw("mid_rst_i_data", i_data, 128'd0);
    chkw("mid_rst_d_data", d_data, 128'd0);
    chk1("mid_rst_timeout_err", timeout_err, 1'b0);
    reset   = 1'b0;
    l2_done = 1'b1;
    l2_data = rand128();
    repeat (4) begin
      @(negedge clk);
      chk1("post_rst_ack", i_ack | d_ack, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
    end
    l2_done = 1'b0;
    model_reset();
    mon_en = 1'b1;
    rsp_en = 1'b1;
    do_i({$urandom(), $urandom()}, 1, 1'b0);
    rand_d(1, 1'b0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/l1_l2_port_arbiter.md
Name: l1_l2_port_arbiter

Overview:
Sequencer/arbiter that shares the single downstream L2 request port between the L1 instruction cache miss path and the L1 data cache miss path (including write-through and CLF cache-line-flush traffic). It accepts at most one outstanding miss at a time. It forwards the miss to L2 with the enable/done handshake and returns the 128-bit line to the requesting L1. Round-robin arbitration prevents either L1 from starving the other; a watchdog flags a hung L2.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before abandoning the L2 access (1..65535)
CNT_W, 16, width of watchdog counter

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
i_req  in  1  L1_I miss request, level, held until i_ack
i_addr  in  64  L1_I miss address
i_ack  out  1  one-cycle pulse: L1_I request complete
i_data  out  128  returned line for L1_I, valid when i_ack=1
d_req  in  1  L1_D request, level, held until d_ack
d_addr  in  64  L1_D address
d_we  in  1  L1_D write enable (1 = write-through)
d_wdata  in  64  L1_D write data
d_wsize  in  3  L1_D write size code, passed through unchanged
d_clf  in  1  L1_D cache line flush
d_ack  out  1  one-cycle pulse: L1_D request complete
d_data  out  128  returned line for L1_D, valid when d_ack=1
l2_enable  out  1  one-cycle request strobe to L2
l2_addr  out  64  latched address
l2_we  out  1  latched write enable (always 0 for I grants)
l2_wdata  out  64  latched write data (0 for I grants)
l2_wsize  out  3  latched size (0 for I grants)
l2_clf  out  1  latched CLF (0 for I grants)
l2_done  in  1  L2 completion, sampled only in WAIT
l2_data  in  128  L2 line, sampled when l2_done=1 in WAIT
busy  out  1  1 in any state other than IDLE
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: state=IDLE, last_grant=I, mask=none, all outputs 0, counter 0, timeout_err 0. Reset mid-transaction aborts it silently: no ack is issued, and the L2 access is dropped.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: eligible = req & ~mask. If only one requester is eligible, grant it. If both are eligible, grant the one that is not last_grant. On grant: latch the request fields into the l2_* registers (I grant: we/wdata/wsize/clf forced 0), record grant owner, clear counter, go to ISSUE. The mask clears after one IDLE cycle.
- ISSUE: l2_enable=1 for exactly this cycle; go to WAIT. l2_done is ignored in ISSUE.
- WAIT: counter increments each cycle.
  - l2_done=1: latch l2_data, go to RESPOND.
  - Counter reaches TIMEOUT_CYCLES-1 with no done: set timeout_err, latched data=0, go to RESPOND.
  - If l2_done and the timeout occur in the same cycle, done wins and timeout_err is not set.
- RESPOND: owner's ack=1 and data=latched line for one cycle. Other ack stays 0. last_grant=owner. mask=owner, which blocks the held-over req for one IDLE cycle. Go to IDLE.
- l2_* address/data outputs hold their latched values from grant until the next grant. i_data/d_data hold the last returned line.
- Latency: req seen in IDLE at cycle 0 -> l2_enable at cycle 1 -> earliest l2_done at cycle 2 -> ack at cycle 3. Minimum 4 cycles between back-to-back grants.
- Request fields are sampled only at grant; later changes are ignored.
- timeout_err clears only on reset.

Test Plan:
- Single I miss: i_req=1, i_addr=19999; L2 returns done 3 cycles after l2_enable with data 0xA5..A5 -> l2_enable for one cycle with l2_addr=19999, l2_we=0; i_ack pulse with i_data=0xA5..A5 on the cycle after l2_done; d_ack stays 0.
- D write-through: d_req=1, d_we=1, d_wdata=0x1122334455667788, d_wsize=3, d_clf=0 -> l2 outputs carry exactly those values; d_ack after l2_done.
- Simultaneous requests, both held: first grant goes to D (last_grant=I after reset), then I, then D. Verify order D,I,D over three completions; no double grant during the mask cycle.
- Watchdog: TIMEOUT_CYCLES=8, l2_done never asserted -> after 8 WAIT cycles, ack with data 0 and timeout_err=1, which stays 1 through later successful transactions.
- l2_done pulsed during ISSUE is ignored; l2_done on the exact timeout cycle -> data returned and timeout_err stays 0.
- reset asserted in WAIT -> next cycle busy=0 and all outputs 0. No ack, even if l2_done arrives afterward. A fresh request completes normally.
